// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/fetch_ctrl_next_pc_sel.sv
// rtl/fetch_ctrl_next_pc_sel.sv - next fetch address mux: trap > misaligned redirect > redirect > pc+4
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
    input  logic [31:0] pc,
    input  logic        trap,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] next_pc,
    output logic        flush,
    output logic        misalign
);

    always_comb begin
        flush    = trap | redirect_valid;
        misalign = !trap && redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (trap || misalign) begin
            next_pc = TRAP_VEC;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else begin
            next_pc = pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC owner and single-outstanding instruction fetch sequencer
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    output logic        misalign_err
);

    fetch_state_e state, state_d;
    logic [31:0]  pc, pc_d;
    logic [31:0]  pend, pend_d;
    logic         drop, drop_d;
    logic         if_valid_d;
    logic [31:0]  if_instr_d, if_pc_d;
    logic [31:0]  next_pc;
    logic         flush, misalign;

    next_pc_sel #(.TRAP_VEC(TRAP_VEC)) u_next_pc_sel (
        .pc             (pc),
        .trap           (trap),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (next_pc),
        .flush          (flush),
        .misalign       (misalign)
    );

    // The request address is the pc itself; a flush during REQ parks in pend so it stays stable.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        pend_d     = pend;
        drop_d     = drop;
        if_valid_d = if_valid;
        if_instr_d = if_instr;
        if_pc_d    = if_pc;
        case (state)
            IDLE: begin
                if (flush) pc_d = next_pc;
                if (en) state_d = REQ;
            end
            REQ: begin
                if (flush) begin
                    pend_d = next_pc;
                    drop_d = 1'b1;
                end
                if (imem_gnt) state_d = RSP;
            end
            RSP: begin
                if (flush) begin
                    pc_d   = next_pc;
                    pend_d = next_pc;
                    drop_d = 1'b1;
                end
                if (imem_rvalid) begin
                    if (drop || flush) begin
                        state_d = REQ;
                        drop_d  = 1'b0;
                        pc_d    = flush ? next_pc : pend;
                    end else begin
                        state_d    = HOLD;
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc;
                    end
                end
            end
            HOLD: begin
                // A flush coincident with the handshake still consumes the instruction; next_pc already prefers the target.
                if (flush) begin
                    pc_d       = next_pc;
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end else if (if_ready) begin
                    pc_d       = next_pc;
                    if_valid_d = 1'b0;
                    state_d    = en ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            pend         <= 32'h0;
            drop         <= 1'b0;
            if_valid     <= 1'b0;
            if_instr     <= NOP_INSTR;
            if_pc        <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            pend         <= pend_d;
            drop         <= drop_d;
            if_valid     <= if_valid_d;
            if_instr     <= if_instr_d;
            if_pc        <= if_pc_d;
            misalign_err <= misalign;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with a memory responder and delivery-order model
module tb_fetch_ctrl;

    localparam logic [31:0] TRAP = 32'h0000_0100;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        trap = 1'b0;
    logic        misalign_err;

    int vectors = 0;
    int miscompares = 0;
    int rsp_delay = 0;
    int rsp_cnt = 0;
    logic rsp_pending = 1'b0;
    logic [31:0] rsp_addr = 32'h0;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap(trap),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock; the responder answers each granted request once, rsp_delay cycles after the RSP cycle opens.
    task automatic tick();
        logic granted;
        logic [31:0] a;
        granted = imem_req & imem_gnt & !rst;
        a = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (granted) begin
            rsp_pending = 1'b1;
            rsp_cnt = rsp_delay;
            rsp_addr = a;
        end
        if (rsp_pending) begin
            if (rsp_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(rsp_addr);
                rsp_pending = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; imem_gnt = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; trap = 1'b0; imem_rvalid = 1'b0;
        rsp_pending = 1'b0; rsp_delay = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (!if_valid && c < 40) begin tick(); c++; end
        vectors++;
        if (!if_valid) begin miscompares++; $display("FAIL %s timeout: if_valid=%b required 1", name, if_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        vectors += 6;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", imem_req); end
        if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", if_valid); end
        if (if_instr !== NOP) begin miscompares++; $display("FAIL reset_instr got %h want %h", if_instr, NOP); end
        if (if_pc !== 32'h0) begin miscompares++; $display("FAIL reset_if_pc got %h want 0", if_pc); end
        if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
    endtask

    task automatic test_sequential();
        int nreq, nhs, last_hs, cyc;
        do_reset();
        en = 1'b1; imem_gnt = 1'b1; if_ready = 1'b1;
        nreq = 0; nhs = 0; last_hs = -1; cyc = 0;
        while (nhs < 3 && cyc < 40) begin
            if (imem_req && imem_gnt) begin
                vectors++;
                if (imem_addr !== 32'(4 * nreq)) begin miscompares++; $display("FAIL seq_addr got %h want %h", imem_addr, 32'(4 * nreq)); end
                nreq++;
            end
            if (if_valid && if_ready) begin
                vectors += 2;
                if (if_pc !== 32'(4 * nhs)) begin miscompares++; $display("FAIL seq_if_pc got %h want %h", if_pc, 32'(4 * nhs)); end
                if (if_instr !== mem_word(32'(4 * nhs))) begin miscompares++; $display("FAIL seq_instr got %h want %h", if_instr, mem_word(32'(4 * nhs))); end
                if (last_hs >= 0) begin
                    vectors++;
                    if (cyc - last_hs != 3) begin miscompares++; $display("FAIL seq_rate got %0d cycles want 3", cyc - last_hs); end
                end
                last_hs = cyc;
                nhs++;
            end
            tick();
            cyc++;
        end
        vectors++;
        if (nhs < 3) begin miscompares++; $display("FAIL seq_timeout got %0d instrs want 3", nhs); end
    endtask

    task automatic test_hold_stall();
        do_reset();
        en = 1'b1; imem_gnt = 1'b1; if_ready = 1'b0;
        wait_valid("stall_reach");
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors += 4;
            if (if_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid got %b want 1", if_valid); end
            if (if_instr !== mem_word(32'h0)) begin miscompares++; $display("FAIL stall_instr got %h want %h", if_instr, mem_word(32'h0)); end
            if (if_pc !== 32'h0) begin miscompares++; $display("FAIL stall_pc got %h want 0", if_pc); end
            if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req got %b want 0", imem_req); end
        end
        if_ready = 1'b1;
        tick();
        vectors += 2;
        if (if_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release got %b want 0", if_valid); end
        if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL stall_next_addr got %h want 4", imem_addr); end
    endtask

    task automatic test_redirect_rsp();
        int c;
        logic seen_req, seen_valid;
        do_reset();
        en = 1'b1; imem_gnt = 1'b1; if_ready = 1'b1; rsp_delay = 1;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        seen_req = 1'b0; seen_valid = 1'b0; c = 0;
        while (!seen_valid && c < 30) begin
            if (imem_req && imem_gnt && !seen_req) begin
                vectors++;
                if (imem_addr !== 32'h200) begin miscompares++; $display("FAIL rsp_redir_addr got %h want 200", imem_addr); end
                seen_req = 1'b1;
            end
            if (if_valid) begin
                vectors += 2;
                if (if_pc !== 32'h200) begin miscompares++; $display("FAIL rsp_redir_pc got %h want 200", if_pc); end
                if (if_instr !== mem_word(32'h200)) begin miscompares++; $display("FAIL rsp_redir_instr got %h want %h", if_instr, mem_word(32'h200)); end
                seen_valid = 1'b1;
            end
            tick();
            c++;
        end
        vectors++;
        if (!seen_valid) begin miscompares++; $display("FAIL rsp_redir_timeout got 0 want 1"); end
    endtask

    task automatic test_redirect_req();
        int c, ngr;
        logic seen_valid;
        do_reset();
        en = 1'b1; imem_gnt = 1'b0; if_ready = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors += 2;
            if (imem_req !== 1'b1) begin miscompares++; $display("FAIL req_redir_req got %b want 1", imem_req); end
            if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL req_redir_hold got %h want 0", imem_addr); end
            if (i < 2) tick();
        end
        imem_gnt = 1'b1;
        ngr = 0; seen_valid = 1'b0; c = 0;
        while (!seen_valid && c < 30) begin
            if (imem_req && imem_gnt) begin
                if (ngr < 2) begin
                    vectors++;
                    if (imem_addr !== (ngr == 0 ? 32'h0 : 32'h200)) begin
                        miscompares++; $display("FAIL req_redir_grant%0d got %h want %h", ngr, imem_addr, (ngr == 0 ? 32'h0 : 32'h200));
                    end
                end
                ngr++;
            end
            if (if_valid) begin
                vectors++;
                if (if_pc !== 32'h200) begin miscompares++; $display("FAIL req_redir_pc got %h want 200", if_pc); end
                seen_valid = 1'b1;
            end
            tick();
            c++;
        end
        vectors++;
        if (!seen_valid) begin miscompares++; $display("FAIL req_redir_timeout got 0 want 1"); end
    endtask

    task automatic test_trap_priority();
        do_reset();
        en = 1'b1; imem_gnt = 1'b1; if_ready = 1'b0;
        wait_valid("trap_reach");
        trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        trap = 1'b0; redirect_valid = 1'b0;
        vectors += 4;
        if (if_valid !== 1'b0) begin miscompares++; $display("FAIL trap_drop got %b want 0", if_valid); end
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL trap_req got %b want 1", imem_req); end
        if (imem_addr !== TRAP) begin miscompares++; $display("FAIL trap_addr got %h want %h", imem_addr, TRAP); end
        if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL trap_misalign got %b want 0", misalign_err); end
        tick();
        wait_valid("misalign_reach");
        vectors++;
        if (if_pc !== TRAP) begin miscompares++; $display("FAIL trap_if_pc got %h want %h", if_pc, TRAP); end
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        tick();
        redirect_valid = 1'b0;
        vectors += 3;
        if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL misalign_pulse got %b want 1", misalign_err); end
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL misalign_req got %b want 1", imem_req); end
        if (imem_addr !== TRAP) begin miscompares++; $display("FAIL misalign_addr got %h want %h", imem_addr, TRAP); end
        tick();
        vectors++;
        if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL misalign_width got %b want 0", misalign_err); end
    endtask

    task automatic test_reset_in_rsp();
        int c;
        do_reset();
        en = 1'b1; imem_gnt = 1'b1; if_ready = 1'b1; rsp_delay = 1;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        vectors += 4;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_req got %b want 0", imem_req); end
        if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_rsp_addr got %h want 0", imem_addr); end
        if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b want 0", if_valid); end
        if (if_instr !== NOP) begin miscompares++; $display("FAIL rst_rsp_instr got %h want %h", if_instr, NOP); end
        en = 1'b0;
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors += 2;
            if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rst_late_rvalid got %b want 0", if_valid); end
            if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_idle_req got %b want 0", imem_req); end
        end
        en = 1'b1;
        c = 0;
        while (!imem_req && c < 10) begin tick(); c++; end
        vectors++;
        if (!imem_req || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_first_addr got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, tgt, held_pc, held_instr, wait_addr;
        logic mis_next, held, req_wait;
        int r, nhs;
        do_reset();
        exp_pc = 32'h0; nhs = 0;
        for (int c = 0; c < 1500; c++) begin
            en = ($urandom_range(0, 9) != 0);
            imem_gnt = ($urandom_range(0, 1) != 0);
            if_ready = ($urandom_range(0, 2) != 0);
            rsp_delay = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 99));
            trap = (r < 3);
            redirect_valid = (r >= 2 && r < 10);
            tgt = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            redirect_pc = tgt;
            // Delivered instructions follow pc+4 from the last one, except the latest flush target restarts the stream.
            if (if_valid && if_ready) begin
                vectors += 2;
                if (if_pc !== exp_pc) begin miscompares++; $display("FAIL rand_pc cycle %0d got %h want %h", c, if_pc, exp_pc); end
                if (if_instr !== mem_word(exp_pc)) begin miscompares++; $display("FAIL rand_instr cycle %0d got %h want %h", c, if_instr, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                nhs++;
            end
            held = if_valid && !if_ready && !trap && !redirect_valid;
            held_pc = if_pc; held_instr = if_instr;
            req_wait = imem_req && !imem_gnt;
            wait_addr = imem_addr;
            mis_next = !trap && redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (trap || mis_next) exp_pc = TRAP;
            else if (redirect_valid) exp_pc = redirect_pc;
            tick();
            vectors++;
            if (misalign_err !== mis_next) begin miscompares++; $display("FAIL rand_misalign cycle %0d got %b want %b", c, misalign_err, mis_next); end
            if (held) begin
                vectors++;
                if (!if_valid || if_pc !== held_pc || if_instr !== held_instr) begin
                    miscompares++; $display("FAIL rand_hold cycle %0d got %b/%h/%h want 1/%h/%h", c, if_valid, if_pc, if_instr, held_pc, held_instr);
                end
            end
            if (req_wait) begin
                vectors++;
                if (!imem_req || imem_addr !== wait_addr) begin
                    miscompares++; $display("FAIL rand_req_stable cycle %0d got %b/%h want 1/%h", c, imem_req, imem_addr, wait_addr);
                end
            end
        end
        trap = 1'b0; redirect_valid = 1'b0;
        vectors++;
        if (nhs < 20) begin miscompares++; $display("FAIL rand_progress got %0d instrs want >=20", nhs); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_rsp();
        test_redirect_req();
        test_trap_priority();
        test_reset_in_rsp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
